// File: rtl/coolgirl_irq_timer_pkg.sv
// coolgirl_irq_pkg: shared constants for the COOLGIRL multi-channel IRQ timer.
//   - register codes carried on wr_reg
//   - control-register bit positions
//   - scanline prescaler constants (341 PPU dots per line, 3 dots per CPU cycle)
//   - sel_width(): width of a channel-select field, never below one bit
// Optional feature macro: COOLGIRL_IRQ_SCANLINE_PRESCALER_EN (see channel file).
package coolgirl_irq_pkg;

  localparam logic [1:0] REG_RELOAD_LO = 2'd0;
  localparam logic [1:0] REG_RELOAD_HI = 2'd1;
  localparam logic [1:0] REG_CTRL      = 2'd2;
  localparam logic [1:0] REG_ACK       = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_SCAN  = 2;
  localparam int CTRL_UP    = 3;
  localparam int CTRL_ACKEN = 4;
  localparam int CTRL_BITS  = 5;

  localparam logic [8:0] PRESC_PERIOD = 9'd341;
  localparam logic [8:0] PRESC_STEP   = 9'd3;

  // Channel-select width: clog2 of the channel count, but at least one bit.
  function automatic int sel_width(input int channels);
    if (channels > 1) begin
      return $clog2(channels);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/coolgirl_irq_timer_if.sv
// coolgirl_irq_timer_if: register-bus bundle between the mapper decoder and
// the IRQ timer.
//   wr_en/wr_ch/wr_reg/wr_data : register write (one m2 cycle per CPU write)
//   rd_ch/rd_hi/rd_data        : counter readback (rd_data combinational)
//   pending/irq                : per-channel pending flags and their OR
// master = decoder side, slave = timer side.
interface coolgirl_irq_timer_if
  import coolgirl_irq_pkg::*;
#(
  parameter int CHANNELS = 2
) ();

  localparam int CH_W = sel_width(CHANNELS);

  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [1:0]          wr_reg;
  logic [7:0]          wr_data;
  logic [CH_W-1:0]     rd_ch;
  logic                rd_hi;
  logic [7:0]          rd_data;
  logic [CHANNELS-1:0] pending;
  logic                irq;

  modport master (
    output wr_en, wr_ch, wr_reg, wr_data, rd_ch, rd_hi,
    input  rd_data, pending, irq
  );

  modport slave (
    input  wr_en, wr_ch, wr_reg, wr_data, rd_ch, rd_hi,
    output rd_data, pending, irq
  );

endinterface

// File: rtl/coolgirl_irq_channel.sv
// coolgirl_irq_channel: one independent IRQ counter.
//   m2      : CPU M2 clock, all state on the rising edge
//   reset   : asynchronous, active-high
//   wr_en   : write strobe already qualified for this channel
//   wr_reg  : register code (reload lo/hi, control, ack)
//   wr_data : write data
//   count   : current counter value (registered)
//   pending : IRQ pending flag (registered)
// With COOLGIRL_IRQ_SCANLINE_PRESCALER_EN defined, a 9-bit prescaler adds 3
// per cycle and ticks on passing 341 (114/114/113 cycle intervals). Without
// it the SCAN control bit is masked off on write and every cycle is a tick.
module coolgirl_irq_channel
  import coolgirl_irq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             m2,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_reg,
  input  logic [7:0]       wr_data,
  output logic [WIDTH-1:0] count,
  output logic             pending
);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] LO_MASK  = WIDTH'(16'h00FF);
`ifdef COOLGIRL_IRQ_SCANLINE_PRESCALER_EN
  localparam logic [CTRL_BITS-1:0] CTRL_WR_MASK = 5'b11111;
`else
  localparam logic [CTRL_BITS-1:0] CTRL_WR_MASK = 5'b11011;
`endif

  logic [WIDTH-1:0]     count_r;
  logic [WIDTH-1:0]     reload_r;
  logic [CTRL_BITS-1:0] ctrl_r;
  logic                 pending_r;

  logic [WIDTH-1:0]     count_nx_s;
  logic [WIDTH-1:0]     reload_nx_s;
  logic [CTRL_BITS-1:0] ctrl_nx_s;
  logic                 pending_nx_s;
  logic                 expire_s;
  logic                 tick_s;

  logic ctrl_wr_s;
  logic ack_wr_s;
  logic rlo_wr_s;
  logic rhi_wr_s;

  assign ctrl_wr_s = wr_en && (wr_reg == REG_CTRL);
  assign ack_wr_s  = wr_en && (wr_reg == REG_ACK);
  assign rlo_wr_s  = wr_en && (wr_reg == REG_RELOAD_LO);
  assign rhi_wr_s  = wr_en && (wr_reg == REG_RELOAD_HI);

`ifdef COOLGIRL_IRQ_SCANLINE_PRESCALER_EN
  logic [8:0] presc_r;
  logic [8:0] presc_nx_s;
  logic [8:0] presc_sum_s;
  logic       wrap_s;

  // Prescaler next state and tick generation; the prescaler only advances
  // while the channel is enabled in scanline mode.
  always_comb begin
    presc_sum_s = presc_r + PRESC_STEP;
    wrap_s      = (presc_sum_s >= PRESC_PERIOD);
    if (ctrl_wr_s) begin
      presc_nx_s = 9'd0;
    end else if (ctrl_r[CTRL_EN] && ctrl_r[CTRL_SCAN]) begin
      presc_nx_s = wrap_s ? (presc_sum_s - PRESC_PERIOD) : presc_sum_s;
    end else begin
      presc_nx_s = presc_r;
    end
    if (ctrl_r[CTRL_SCAN]) begin
      tick_s = wrap_s;
    end else begin
      tick_s = 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      presc_r <= 9'd0;
    end else begin
      presc_r <= presc_nx_s;
    end
  end
`else
  // SCAN is masked to 0 on write, so this is a tick on every cycle.
  assign tick_s = ~ctrl_r[CTRL_SCAN];
`endif

  // Counter, reload, control and pending next state. A control write
  // overrides everything on its edge (the coinciding tick is dropped); an
  // expiry beats a simultaneous ack for the pending flag.
  always_comb begin
    count_nx_s   = count_r;
    reload_nx_s  = reload_r;
    ctrl_nx_s    = ctrl_r;
    pending_nx_s = pending_r;
    expire_s     = 1'b0;
    if (ctrl_wr_s) begin
      ctrl_nx_s    = wr_data[CTRL_BITS-1:0] & CTRL_WR_MASK;
      count_nx_s   = reload_r;
      pending_nx_s = 1'b0;
    end else begin
      if (ctrl_r[CTRL_EN] && tick_s) begin
        if (ctrl_r[CTRL_UP]) begin
          if (count_r == ALL_ONES) begin
            expire_s   = 1'b1;
            count_nx_s = ctrl_r[CTRL_AUTO] ? reload_r : ZERO;
          end else begin
            count_nx_s = count_r + ONE;
          end
        end else begin
          if (count_r == ZERO) begin
            expire_s   = 1'b1;
            count_nx_s = ctrl_r[CTRL_AUTO] ? reload_r : ALL_ONES;
          end else begin
            count_nx_s = count_r - ONE;
          end
        end
      end else begin
        count_nx_s = count_r;
      end

      if (expire_s) begin
        pending_nx_s = 1'b1;
      end else if (ack_wr_s) begin
        pending_nx_s = 1'b0;
      end else begin
        pending_nx_s = pending_r;
      end

      // A one-shot expiry disables the channel even if acked on that edge.
      if (expire_s && !ctrl_r[CTRL_AUTO]) begin
        ctrl_nx_s[CTRL_EN] = 1'b0;
      end else if (ack_wr_s) begin
        ctrl_nx_s[CTRL_EN] = ctrl_r[CTRL_ACKEN];
      end else begin
        ctrl_nx_s[CTRL_EN] = ctrl_r[CTRL_EN];
      end

      // Reload writes never touch count; an auto-reload on the same edge
      // uses the old reload value. High-byte writes vanish when WIDTH = 8.
      if (rlo_wr_s) begin
        reload_nx_s = (reload_r & ~LO_MASK) | WIDTH'(wr_data);
      end else if (rhi_wr_s) begin
        reload_nx_s = (reload_r & LO_MASK) | WIDTH'({wr_data, 8'h00});
      end else begin
        reload_nx_s = reload_r;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      count_r   <= ZERO;
      reload_r  <= ZERO;
      ctrl_r    <= 5'b00000;
      pending_r <= 1'b0;
    end else begin
      count_r   <= count_nx_s;
      reload_r  <= reload_nx_s;
      ctrl_r    <= ctrl_nx_s;
      pending_r <= pending_nx_s;
    end
  end

  assign count   = count_r;
  assign pending = pending_r;

endmodule

// File: rtl/coolgirl_irq_timer.sv
// coolgirl_irq_timer: CHANNELS independent CPU-cycle/scanline IRQ counters.
//   m2    : CPU M2 clock
//   reset : asynchronous, active-high
//   bus   : coolgirl_irq_timer_if.slave (write port, readback, pending, irq)
// Holds the write decode, the readback mux and the irq OR; each counter
// lives in coolgirl_irq_channel. The scanline prescaler is built only when
// COOLGIRL_IRQ_SCANLINE_PRESCALER_EN is defined.
module coolgirl_irq_timer
  import coolgirl_irq_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16
) (
  input  logic                 m2,
  input  logic                 reset,
  coolgirl_irq_timer_if.slave  bus
);

  localparam int CH_W = sel_width(CHANNELS);

  logic [CHANNELS-1:0] pending_s;
  logic [7:0]          sel_byte_s [CHANNELS];
  logic [7:0]          rd_data_s;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             ch_wr_s;
    logic [WIDTH-1:0] count_s;
    logic [15:0]      count_ext_s;

    assign ch_wr_s     = bus.wr_en && (bus.wr_ch == CH_W'(g));
    assign count_ext_s = 16'(count_s);
    // Byte this channel offers to the readback OR (zero when not selected).
    assign sel_byte_s[g] = (bus.rd_ch == CH_W'(g))
                         ? (bus.rd_hi ? count_ext_s[15:8] : count_ext_s[7:0])
                         : 8'h00;

    coolgirl_irq_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .m2      (m2),
      .reset   (reset),
      .wr_en   (ch_wr_s),
      .wr_reg  (bus.wr_reg),
      .wr_data (bus.wr_data),
      .count   (count_s),
      .pending (pending_s[g])
    );
  end

  // Readback mux: at most one channel offers a non-zero byte.
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      rd_data_s = rd_data_s | sel_byte_s[i];
    end
  end

  assign bus.rd_data = rd_data_s;
  assign bus.pending = pending_s;
  assign bus.irq     = |pending_s;

endmodule

// File: doc/coolgirl_irq_timer.md
# coolgirl_irq_timer

Multi-channel CPU-cycle/scanline IRQ timer for the COOLGIRL multicart. It generalises the mapper-specific IRQ counters (VRC4, FME-7, #042, #048) into CHANNELS independent counters. Each counter has a configurable width, count direction, reload behaviour and an optional 341/3 scanline prescaler. It sits beside the mapper register decoder, clocked by `m2`, and drives the cartridge IRQ line.

## Interface
- CHANNELS, 2: number of independent counters (1..4).
- WIDTH, 16: counter width in bits (8..16).
- CH_W, derived: max(1, clog2(CHANNELS)); not user-set.
- m2  in  1  CPU M2 clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- wr_en  in  1  register write strobe, one m2 cycle per CPU write.
- wr_ch  in  CH_W  target channel.
- wr_reg  in  2  register: 0 = reload low, 1 = reload high, 2 = control, 3 = ack.
- wr_data  in  8  write data.
- rd_ch  in  CH_W  read channel select.
- rd_hi  in  1  0 = count[7:0], 1 = count[WIDTH-1:8] zero-extended.
- rd_data  out  8  combinational counter readback.
- pending  out  CHANNELS  per-channel IRQ pending flags.
- irq  out  1  OR of `pending`, active-high; the top level inverts it for /IRQ.

## Operation
- Per-channel state: `count`[WIDTH], `reload`[WIDTH], `ctrl`[5], `pending`, `presc`[9].
- Control bit 0 EN: counter enable.
- Control bit 1 AUTO: automatic reload.
- Control bit 2 SCAN: prescaled (scanline) mode.
- Control bit 3 UP: count direction, 0 = down, 1 = up.
- Control bit 4 ACKEN: value EN takes on ack.
- Reload low write: `reload[7:0]` = wr_data.
- Reload high write: `reload[WIDTH-1:8]` = wr_data[WIDTH-9:0]. This write is ignored when WIDTH = 8.
- A reload write never touches `count`.
- Control write: `ctrl` = wr_data[4:0]; `count` = `reload`; `presc` = 0; `pending` = 0.
- Ack write: `pending` = 0; EN = ACKEN. Count and prescaler are unaffected.
- Tick source: every m2 cycle when SCAN = 0. When SCAN = 1, `presc` += 3 each cycle; if the sum is ≥ 341, subtract 341 and emit a tick. Tick intervals are 114, 114, 113 cycles.
- On a tick with EN = 1, down mode:
  - if `count` = 0: set `pending`; `count` = AUTO ? `reload` : all-ones; if AUTO = 0, clear EN.
  - otherwise: `count` − 1.
- On a tick with EN = 1, up mode:
  - if `count` = all-ones: set `pending`; `count` = AUTO ? `reload` : 0; if AUTO = 0, clear EN.
  - otherwise: `count` + 1.
- With EN = 0, `count` and `presc` hold.
- Channels are fully independent. A write to one channel never affects another.

## Timing
- Reset: all counts, reloads, controls, prescalers and pending flags are 0; `irq` = 0; `rd_data` = 0.
- Reset asserted mid-count clears the channel immediately. Counting resumes only after a new control write.
- Writes take effect on the m2 edge that samples `wr_en`.
- `pending` sets on the expiring tick edge. `irq` follows it combinationally, with no extra cycle.
- Down-mode period = `reload` + 1 ticks. Up-mode period = 2^WIDTH − `reload` ticks.
- Control write coinciding with a tick on the same channel: the write wins and the tick is dropped.
- Ack coinciding with expiry on the same channel: `pending` ends set, because the new event wins. EN takes the expiry result if AUTO = 0, otherwise ACKEN.
- Reload write coinciding with an auto-reload: the old `reload` is loaded into `count`; the new value is stored.

## Configuration
- `COOLGIRL_IRQ_SCANLINE_PRESCALER_EN` defined: SCAN bit is honoured and the prescaler is built.
- Macro undefined:
  - SCAN is forced to 0 and the `presc` registers are removed.
  - Ticks occur every m2 cycle.
  - A written SCAN bit has no effect.

## Structure
- Package `coolgirl_irq_pkg`:
  - register codes REG_RELOAD_LO/HI, REG_CTRL, REG_ACK;
  - control bit indices CTRL_EN, CTRL_AUTO, CTRL_SCAN, CTRL_UP, CTRL_ACKEN;
  - PRESC_PERIOD = 341, PRESC_STEP = 3.
- Sub-module `coolgirl_irq_channel`, parameterised by WIDTH, instantiated CHANNELS times via generate.
- The top wrapper holds write decode, the read mux and the `irq` OR.

## Test plan
- Down, reload = 3, control = 0x03 (EN, AUTO) → `pending` sets on the 4th m2 edge after the write; count 3 again; repeats every 4 cycles.
- Up, WIDTH = 8, reload = 0xFE, control = 0x09 (EN, UP, non-auto) → pending after 2 ticks; count = 0; EN cleared; no further events.
- SCAN mode, reload = 0, control = 0x07 → ticks at cycles 114, 228, 341, 455; pending at the first tick. Macro undefined → pending at cycle 1.
- Ack with ACKEN = 1 while pending → `pending` = 0, `irq` = 0, counting continues. Ack on the same edge as an expiry → `pending` stays 1.
- Two channels: ch0 period 5, ch1 period 7; a write to ch1 mid-run → ch0 is undisturbed and `irq` asserts on each channel's event.
- Reset asserted between ticks → all outputs are 0 immediately. `rd_data` reads 0 for both channels, both halves.
